// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative EX-stage divider: FSM encodings and the
// HI/LO write-back selector value that routes the divider result.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BUSY    = 2'b01,
    DIV_DIVZERO = 2'b10,
    DIV_DONE    = 2'b11
  } div_state_e;

  // DatatoHI/LO select value meaning "write HI/LO from the divider".
  localparam logic [1:0] DATATOHILO_DIV = 2'b10;

endpackage

// File: rtl/div_iter_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it does not go negative.
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted_rem_d;
  logic [DATA_W:0] trial_d;

  // Trial subtraction on DATA_W+1 bits; the MSB is the borrow (negative) flag.
  always_comb begin
    shifted_rem_d = {rem_i, quo_i[DATA_W-1]};
    trial_d       = shifted_rem_d - {1'b0, divisor_i};
    if (trial_d[DATA_W] == 1'b0) begin
      rem_o = trial_d[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      // Restored remainder is below the divisor, so it always fits in DATA_W bits.
      rem_o = shifted_rem_d[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX. Produces {HI=rem, LO=quo}
// with a one-cycle DivReadyE pulse after 33 cycles (1 cycle for a zero divisor).
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  StartDivE,
  input  logic                  SignedDivE,
  input  logic [DATA_W-1:0]     SrcAE,
  input  logic [DATA_W-1:0]     SrcBE,
  input  logic                  Annul,
  output logic [2*DATA_W-1:0]   DivResultE,
  output logic                  DivReadyE
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES_W   = {DATA_W{1'b1}};

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] divisor_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic [DATA_W-1:0] abs_a_d;
  logic [DATA_W-1:0] abs_b_d;
  logic [DATA_W-1:0] step_rem_d;
  logic [DATA_W-1:0] step_quo_d;
  logic [DATA_W-1:0] quo_final_d;
  logic [DATA_W-1:0] rem_final_d;

  // Magnitudes of the operands; negating 0x80000000 yields 0x80000000, which is
  // the correct unsigned magnitude, so no wider path is needed here.
  always_comb begin
    if (SignedDivE && SrcAE[DATA_W-1]) begin
      abs_a_d = (~SrcAE) + ONE_W;
    end else begin
      abs_a_d = SrcAE;
    end
    if (SignedDivE && SrcBE[DATA_W-1]) begin
      abs_b_d = (~SrcBE) + ONE_W;
    end else begin
      abs_b_d = SrcBE;
    end
  end

  div_iter_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_d),
    .quo_o     (step_quo_d)
  );

  // Sign correction applied to the output of the final iteration.
  always_comb begin
    if (neg_quo_q) begin
      quo_final_d = (~step_quo_d) + ONE_W;
    end else begin
      quo_final_d = step_quo_d;
    end
    if (neg_rem_q) begin
      rem_final_d = (~step_rem_d) + ONE_W;
    end else begin
      rem_final_d = step_rem_d;
    end
  end

  // Control FSM, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= ZERO_W;
      quo_q      <= ZERO_W;
      divisor_q  <= ZERO_W;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      DivResultE <= {2*DATA_W{1'b0}};
      DivReadyE  <= 1'b0;
    end else if (Annul) begin
      // Flush beats everything, including a fresh start; the old result is kept.
      state_q   <= DIV_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      DivReadyE <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          DivReadyE <= 1'b0;
          cnt_q     <= {CNT_W{1'b0}};
          if (StartDivE) begin
            if (SrcBE == ZERO_W) begin
              state_q    <= DIV_DIVZERO;
              DivResultE <= {SrcAE, ONES_W};
              DivReadyE  <= 1'b1;
            end else begin
              state_q   <= DIV_BUSY;
              rem_q     <= ZERO_W;
              quo_q     <= abs_a_d;
              divisor_q <= abs_b_d;
              neg_quo_q <= SignedDivE & (SrcAE[DATA_W-1] ^ SrcBE[DATA_W-1]);
              neg_rem_q <= SignedDivE & SrcAE[DATA_W-1];
            end
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          if (!StartDivE) begin
            // Start dropped mid-operation: the instruction went away, abandon it.
            state_q   <= DIV_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            DivReadyE <= 1'b0;
          end else begin
            rem_q <= step_rem_d;
            quo_q <= step_quo_d;
            if (cnt_q == CNT_LAST) begin
              state_q    <= DIV_DONE;
              cnt_q      <= {CNT_W{1'b0}};
              DivResultE <= {rem_final_d, quo_final_d};
              DivReadyE  <= 1'b1;
            end else begin
              state_q   <= DIV_BUSY;
              cnt_q     <= cnt_q + CNT_ONE;
              DivReadyE <= 1'b0;
            end
          end
        end
        DIV_DIVZERO, DIV_DONE: begin
          // Ready cycle: the pipeline advances at this edge, so start is ignored here.
          state_q   <= DIV_IDLE;
          cnt_q     <= {CNT_W{1'b0}};
          DivReadyE <= 1'b0;
        end
        default: begin
          state_q   <= DIV_IDLE;
          cnt_q     <= {CNT_W{1'b0}};
          DivReadyE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide-by-zero,
// annul, start drop, mid-operation reset and back-to-back operation.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        StartDivE;
  logic        SignedDivE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        Annul;
  logic [63:0] DivResultE;
  logic        DivReadyE;

  int checks;
  int errors;

  div_iter #(.DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .StartDivE  (StartDivE),
    .SignedDivE (SignedDivE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .Annul      (Annul),
    .DivResultE (DivResultE),
    .DivReadyE  (DivReadyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the number of edges until DivReadyE is seen, or 0 on timeout.
  task automatic wait_ready(input int max_cyc, output int lat);
    int n;
    n   = 0;
    lat = 0;
    while (lat == 0 && n < max_cyc) begin
      tick();
      n++;
      if (DivReadyE === 1'b1) lat = n;
    end
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    SignedDivE = sgn;
    SrcAE      = a;
    SrcBE      = b;
    StartDivE  = 1'b1;
    wait_ready(40, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, DivResultE, exp_res);
    StartDivE = 1'b0;
    tick();
    chk({tag, "_pulse"}, {63'd0, DivReadyE}, 64'd0);
  endtask

  initial begin
    int lat;
    int lat2;
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    StartDivE  = 1'b0;
    SignedDivE = 1'b0;
    SrcAE      = 32'd0;
    SrcBE      = 32'd0;
    Annul      = 1'b0;
    tick();
    tick();
    chk("reset_res", DivResultE, 64'd0);
    chk("reset_rdy", {63'd0, DivReadyE}, 64'd0);
    resetn = 1'b1;
    tick();

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    do_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);

    // Annul at cycle 10 of a busy divide, then a fresh 9/3 from IDLE.
    SignedDivE = 1'b0;
    SrcAE      = 32'd100;
    SrcBE      = 32'd7;
    StartDivE  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("annul_busy_rdy", {63'd0, DivReadyE}, 64'd0);
    Annul = 1'b1;
    tick();
    chk("annul_rdy", {63'd0, DivReadyE}, 64'd0);
    chk("annul_res_kept", DivResultE, {32'd5, 32'hFFFF_FFFF});
    Annul = 1'b0;
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Annul together with start in IDLE: start is ignored for that edge.
    SignedDivE = 1'b0;
    SrcAE      = 32'd5;
    SrcBE      = 32'd0;
    StartDivE  = 1'b1;
    Annul      = 1'b1;
    tick();
    chk("annul_start_rdy", {63'd0, DivReadyE}, 64'd0);
    Annul = 1'b0;
    wait_ready(40, lat);
    chk("annul_start_lat", 64'(lat), 64'd1);
    StartDivE = 1'b0;
    tick();

    // Reset at cycle 20 of a busy divide.
    SrcAE     = 32'd100;
    SrcBE     = 32'd7;
    StartDivE = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    resetn = 1'b0;
    tick();
    chk("midreset_res", DivResultE, 64'd0);
    chk("midreset_rdy", {63'd0, DivReadyE}, 64'd0);
    resetn    = 1'b1;
    StartDivE = 1'b0;
    wait_ready(40, lat);
    chk("midreset_no_ready", 64'(lat), 64'd0);

    // Back-to-back: start stays high across the first ready cycle.
    SignedDivE = 1'b0;
    SrcAE      = 32'd100;
    SrcBE      = 32'd7;
    StartDivE  = 1'b1;
    wait_ready(40, lat);
    chk("b2b_first_lat", 64'(lat), 64'd33);
    chk("b2b_first_res", DivResultE, {32'd2, 32'd14});
    SrcAE = 32'd50;
    SrcBE = 32'd5;
    wait_ready(80, lat2);
    chk("b2b_second_cycle", 64'(lat + lat2), 64'd67);
    chk("b2b_second_res", DivResultE, {32'd0, 32'd10});
    StartDivE = 1'b0;
    tick();

    // Start dropping while busy abandons the divide without a ready pulse.
    SrcAE     = 32'd100;
    SrcBE     = 32'd7;
    StartDivE = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    StartDivE = 1'b0;
    wait_ready(45, lat);
    chk("drop_no_ready", 64'(lat), 64'd0);
    chk("drop_res_kept", DivResultE, {32'd0, 32'd10});
    do_div("after_drop_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
